adder_arbiter: RTL and testbench

//  Shares one WIDTH-bit FullAdder datapath among NREQ requesters, using a round-robin grant.
//  - Per-requester valid/ready request and response channels.
//  - The block drives the adder operand pins and captures Sum/Carry after ADD_LAT cycles.
//  - Sits between ALU-side clients and the single FullAdder instance in the ALU top.

---
 rtl/adder_arbiter.sv | 171 +++++++++++++++++
 tb/tb_adder_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin arbiter sharing one adder datapath among NREQ requesters
//
// Purpose:
//   Several clients share a single WIDTH-bit full adder. A round-robin
//   arbiter grants one request at a time. The block latches the winner's
//   operands and drives them onto the adder pins. After ADD_LAT cycles it
//   captures the adder sum and carry. It then presents that result on a
//   shared response bus until the granted requester accepts it.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester request handshake (ready is one-hot)
//   req_a/req_b/req_cin   packed per-requester operands, slice i*WIDTH +: WIDTH
//   rsp_valid/rsp_ready   per-requester response handshake (valid is one-hot)
//   rsp_sum/rsp_cout      captured result, shared bus qualified by rsp_valid
//   add_a/add_b/add_cin   operands to the external adder
//   add_sum/add_cout      result from the external adder
//   busy                  high whenever an operation is in flight
//   grant_id              index of the current or most recent grant

module adder_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NREQ    = 4,
    parameter int ADD_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ*WIDTH-1:0]       req_a,
    input  logic [NREQ*WIDTH-1:0]       req_b,
    input  logic [NREQ-1:0]             req_cin,
    output logic [NREQ-1:0]             rsp_valid,
    input  logic [NREQ-1:0]             rsp_ready,
    output logic [WIDTH-1:0]            rsp_sum,
    output logic                        rsp_cout,
    output logic [WIDTH-1:0]            add_a,
    output logic [WIDTH-1:0]            add_b,
    output logic                        add_cin,
    input  logic [WIDTH-1:0]            add_sum,
    input  logic                        add_cout,
    output logic                        busy,
    output logic [$clog2(NREQ)-1:0]     grant_id
);

    localparam int IW = $clog2(NREQ);
    // The counter only ever holds values 0..ADD_LAT-1.
    localparam int CW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [IW-1:0]      r_last;
    logic [IW-1:0]      r_grant;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic               r_op_cin;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic               w_found;
    logic [IW-1:0]      w_sel;
    logic [NREQ-1:0]    w_req_ready;
    logic [NREQ-1:0]    w_rsp_valid;
    logic               w_accept;
    logic               w_capture;

    // Requester index reached by stepping 'off' places past 'base', modulo NREQ.
    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int off);
        int t;
        t = (int'(base) + off) % NREQ;
        return IW'(t);
    endfunction

    // Round-robin search. It starts just after the last grant, so the most
    // recently served requester is considered last.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int j = 1; j <= NREQ; j++) begin
            if (!w_found && req_valid[rr_idx(r_last, j)]) begin
                w_found = 1'b1;
                w_sel   = rr_idx(r_last, j);
            end
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        w_next_state = r_state;
        w_req_ready  = '0;
        w_rsp_valid  = '0;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_req_ready[w_sel] = 1'b1;
                    w_accept           = 1'b1;
                    w_next_state       = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_capture    = 1'b1;
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                w_rsp_valid[r_grant] = 1'b1;
                // Only the granted requester's ready can complete the response.
                if (rsp_ready[r_grant]) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_last   <= IW'(NREQ - 1);
            r_grant  <= '0;
            r_cnt    <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_op_cin <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_op_a   <= req_a[w_sel*WIDTH +: WIDTH];
                r_op_b   <= req_b[w_sel*WIDTH +: WIDTH];
                r_op_cin <= req_cin[w_sel];
                r_grant  <= w_sel;
                r_last   <= w_sel;
                r_cnt    <= CW'(ADD_LAT - 1);
            end else if (r_state == S_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_capture) begin
                r_sum  <= add_sum;
                r_cout <= add_cout;
            end
        end
    end

    // The FSM sits in IDLE while reset is held. Gating with rst_n keeps
    // req_ready low for the whole reset period, not just after it.
    assign req_ready = rst_n ? w_req_ready : '0;
    assign rsp_valid = w_rsp_valid;
    assign rsp_sum   = r_sum;
    assign rsp_cout  = r_cout;
    assign add_a     = r_op_a;
    assign add_b     = r_op_b;
    assign add_cin   = r_op_cin;
    assign busy      = (r_state != S_IDLE);
    assign grant_id  = r_grant;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - randomized model-checked bench for adder_arbiter (ADD_LAT 1 and 3)

module tb_adder_arbiter;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst_n;

    logic [N-1:0]    req_valid [2];
    logic [N-1:0]    req_ready [2];
    logic [N*W-1:0]  req_a     [2];
    logic [N*W-1:0]  req_b     [2];
    logic [N-1:0]    req_cin   [2];
    logic [N-1:0]    rsp_valid [2];
    logic [N-1:0]    rsp_ready [2];
    logic [W-1:0]    rsp_sum   [2];
    logic            rsp_cout  [2];
    logic [W-1:0]    add_a     [2];
    logic [W-1:0]    add_b     [2];
    logic            add_cin   [2];
    logic [W-1:0]    add_sum   [2];
    logic            add_cout  [2];
    logic            busy      [2];
    logic [IW-1:0]   grant_id  [2];

    int vectors     = 0;
    int miscompares = 0;
    int lat [2] = '{1, 3};

    // Reference model of the block, one entry per instance.
    bit          m_active [2];
    int          m_age    [2];
    int          m_gid    [2];
    int          m_last   [2];
    logic [W:0]  m_pend   [2];
    logic [W:0]  m_cap    [2];
    logic [W-1:0] m_opa   [2];
    logic [W-1:0] m_opb   [2];
    logic        m_opc    [2];
    int          acc_g    [2];

    always #5 clk = ~clk;

    adder_arbiter #(.WIDTH(W), .NREQ(N), .ADD_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_a(req_a[0]), .req_b(req_b[0]), .req_cin(req_cin[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_sum(rsp_sum[0]), .rsp_cout(rsp_cout[0]),
        .add_a(add_a[0]), .add_b(add_b[0]), .add_cin(add_cin[0]),
        .add_sum(add_sum[0]), .add_cout(add_cout[0]),
        .busy(busy[0]), .grant_id(grant_id[0])
    );

    adder_arbiter #(.WIDTH(W), .NREQ(N), .ADD_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_a(req_a[1]), .req_b(req_b[1]), .req_cin(req_cin[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_sum(rsp_sum[1]), .rsp_cout(rsp_cout[1]),
        .add_a(add_a[1]), .add_b(add_b[1]), .add_cin(add_cin[1]),
        .add_sum(add_sum[1]), .add_cout(add_cout[1]),
        .busy(busy[1]), .grant_id(grant_id[1])
    );

    // Adder for ADD_LAT=1: combinational.
    assign {add_cout[0], add_sum[0]} = {1'b0, add_a[0]} + {1'b0, add_b[0]} + {32'd0, add_cin[0]};

    // Adder for ADD_LAT=3: the result reaches the pins two edges after the
    // operands change. It is therefore settled at the third edge after accept.
    logic [W:0] p1, p2;
    always @(posedge clk) begin
        p1 <= {1'b0, add_a[1]} + {1'b0, add_b[1]} + {32'd0, add_cin[1]};
        p2 <= p1;
    end
    assign {add_cout[1], add_sum[1]} = p2;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mreset(input int k);
        m_active[k] = 1'b0;
        m_age[k]    = 0;
        m_gid[k]    = 0;
        m_last[k]   = N - 1;
        m_pend[k]   = '0;
        m_cap[k]    = '0;
        m_opa[k]    = '0;
        m_opb[k]    = '0;
        m_opc[k]    = 1'b0;
    endtask

    function automatic int arb(input int k);
        if (!rst_n) return -1;
        for (int j = 1; j <= N; j++) begin
            if (req_valid[k][(m_last[k] + j) % N]) return (m_last[k] + j) % N;
        end
        return -1;
    endfunction

    task automatic check_all();
        logic [N-1:0] er, ev;
        int g;
        for (int k = 0; k < 2; k++) begin
            g  = arb(k);
            er = '0;
            ev = '0;
            if (!m_active[k] && g >= 0) er[g] = 1'b1;
            if (m_active[k] && m_age[k] >= lat[k]) ev[m_gid[k]] = 1'b1;
            chk($sformatf("busy[%0d]", k), busy[k], m_active[k]);
            chk($sformatf("req_ready[%0d]", k), req_ready[k], er);
            chk($sformatf("rsp_valid[%0d]", k), rsp_valid[k], ev);
            chk($sformatf("rsp_result[%0d]", k), {rsp_cout[k], rsp_sum[k]}, m_cap[k]);
            chk($sformatf("grant_id[%0d]", k), grant_id[k], m_gid[k]);
            chk($sformatf("add_ops[%0d]", k), {add_cin[k], add_a[k], add_b[k]},
                {m_opc[k], m_opa[k], m_opb[k]});
        end
    endtask

    // Apply the effect of the coming rising edge to the model, then move to the next falling edge.
    task automatic advance();
        int g;
        for (int k = 0; k < 2; k++) begin
            acc_g[k] = -1;
            if (rst_n) begin
                if (!m_active[k]) begin
                    g = arb(k);
                    if (g >= 0) begin
                        acc_g[k]    = g;
                        m_active[k] = 1'b1;
                        m_age[k]    = 0;
                        m_gid[k]    = g;
                        m_last[k]   = g;
                        m_opa[k]    = req_a[k][g*W +: W];
                        m_opb[k]    = req_b[k][g*W +: W];
                        m_opc[k]    = req_cin[k][g];
                        m_pend[k]   = {1'b0, m_opa[k]} + {1'b0, m_opb[k]} + {32'd0, m_opc[k]};
                    end
                end else if (m_age[k] >= lat[k]) begin
                    if (rsp_ready[k][m_gid[k]]) m_active[k] = 1'b0;
                end else begin
                    m_age[k]++;
                    if (m_age[k] == lat[k]) m_cap[k] = m_pend[k];
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step();
        #1;
        check_all();
        advance();
    endtask

    function automatic logic [W-1:0] rand_word();
        case ($urandom_range(0, 7))
            0:       return '1;
            1:       return '0;
            default: return $urandom;
        endcase
    endfunction

    task automatic set_op(input int k, input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c);
        req_valid[k][r]     = 1'b1;
        req_a[k][r*W +: W]  = a;
        req_b[k][r*W +: W]  = b;
        req_cin[k][r]       = c;
    endtask

    task automatic rand_stim();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[k][i] && acc_g[k] == i) req_valid[k][i] = 1'b0;
                if (!req_valid[k][i] && $urandom_range(0, 3) == 0)
                    set_op(k, i, rand_word(), rand_word(), 1'($urandom_range(0, 1)));
                rsp_ready[k][i] = ($urandom_range(0, 2) != 0);
            end
        end
    endtask

    // Let every pending request on instance k be served, with responses always accepted.
    task automatic serve_all(input int k);
        int s;
        rsp_ready[k] = '1;
        for (s = 0; s < 60; s++) begin
            if (req_valid[k] == '0 && !busy[k]) break;
            step();
            if (acc_g[k] >= 0) req_valid[k][acc_g[k]] = 1'b0;
        end
        chk($sformatf("serve_timeout[%0d]", k), (s < 60), 1);
    endtask

    task automatic single_op(input int k, input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic c, input logic [W:0] exp, input string nm);
        int n;
        rsp_ready[k] = '1;
        set_op(k, r, a, b, c);
        step();
        chk({nm, "_grant"}, acc_g[k], r);
        req_valid[k][r] = 1'b0;
        n = 0;
        while (rsp_valid[k] == '0 && n < 20) begin
            step();
            n++;
        end
        chk({nm, "_latency"}, n, lat[k]);
        chk({nm, "_result"}, {rsp_cout[k], rsp_sum[k]}, exp);
        step();
    endtask

    initial begin
        int seq [5] = '{0, 1, 2, 3, 0};
        int ng, prev, n;

        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = '0; req_a[k] = '0; req_b[k] = '0;
            req_cin[k] = '0; rsp_ready[k] = '0; acc_g[k] = -1;
            mreset(k);
        end
        @(negedge clk);
        step();
        step();
        chk("reset_busy", busy[0], 0);
        chk("reset_grant_id", grant_id[1], 0);
        rst_n = 1'b1;

        // Single operations and carry corner cases.
        single_op(0, 0, 32'd5, 32'd7, 1'b1, 33'd13, "t1");
        single_op(0, 1, 32'hFFFF_FFFF, 32'd1, 1'b0, 33'h1_0000_0000, "t2a");
        single_op(0, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF, "t2b");
        single_op(1, 2, 32'h8000_0001, 32'h7FFF_FFFF, 1'b1, 33'h1_0000_0001, "t6");

        // Contention from reset: every grant re-requests at once.
        rst_n = 1'b0;
        mreset(0); mreset(1);
        for (int i = 0; i < N; i++) set_op(0, i, $urandom, $urandom, 1'($urandom_range(0, 1)));
        rsp_ready[0] = '1;
        step();
        rst_n = 1'b1;
        ng = 0; prev = 0;
        for (int s = 0; s < 40 && ng < 5; s++) begin
            step();
            if (acc_g[0] >= 0) begin
                chk("t3_order", acc_g[0], seq[ng]);
                if (ng > 0) chk("t3_period", s - prev, 3);
                prev = s;
                ng++;
                set_op(0, acc_g[0], $urandom, $urandom, 1'($urandom_range(0, 1)));
            end
        end
        chk("t3_grants", ng, 5);
        serve_all(0);

        // Backpressure: req2 holds off its response; the other readies are ignored.
        rsp_ready[0] = 4'b1011;
        set_op(0, 2, $urandom, $urandom, 1'b1);
        step();
        chk("t4_grant", acc_g[0], 2);
        req_valid[0][2] = 1'b0;
        set_op(0, 0, $urandom, $urandom, 1'b0);
        n = 0;
        while (rsp_valid[0] == '0 && n < 20) begin
            step();
            n++;
        end
        for (int s = 0; s < 5; s++) begin
            chk("t4_hold_valid", rsp_valid[0], 4'b0100);
            step();
            chk("t4_no_accept", acc_g[0], -1);
        end
        rsp_ready[0][2] = 1'b1;
        step();
        step();
        chk("t4_next_grant", acc_g[0], 0);
        req_valid[0][0] = 1'b0;
        serve_all(0);

        // Reset in the middle of an operation.
        set_op(0, 1, $urandom, $urandom, 1'b0);
        step();
        chk("t5_grant", acc_g[0], 1);
        for (int i = 0; i < N; i++) set_op(0, i, $urandom, $urandom, 1'($urandom_range(0, 1)));
        rst_n = 1'b0;
        mreset(0); mreset(1);
        #1;
        chk("t5_rsp_valid", rsp_valid[0], 0);
        chk("t5_busy", busy[0], 0);
        chk("t5_req_ready", req_ready[0], 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("t5_first_grant", acc_g[0], 0);
        req_valid[0][0] = 1'b0;
        serve_all(0);

        // Random traffic on both instances, with an occasional reset.
        for (int s = 0; s < 3000; s++) begin
            rand_stim();
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                mreset(0); mreset(1);
                step();
                step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
